// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: the PC-source select (also decoded by the control unit),
// the fetch FSM states, and the NOP word used after reset and after a fetch error.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    WAIT = 2'b01,
    HALT = 2'b10,
    HOLD = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

  function automatic logic is_word_aligned(input logic [1:0] i_addr_lsbs);
    return i_addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux for the fetch stage: sequential, branch/jal target or jalr target,
// plus a flag when the selected address is not word-aligned.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_imm_ext,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);

  always_comb begin
    // NOTE: default assignment first, so every path drives o_next_pc and no latch is inferred.
    o_next_pc = i_pc + PC_INCR;
    case (pcsrc_e'(i_pc_src))
      PC_TARGET: o_next_pc = i_pc + i_imm_ext;
      PC_ALU:    o_next_pc = i_alu_result & ~32'h1;
      default:   ;  // PC_PLUS4 and the reserved code both take PC+4
    endcase
  end

  assign o_misaligned = !is_word_aligned(o_next_pc[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding reads and presents Instr
// with a valid/ready handshake. Define FETCH_PERF_CNT_EN to build the saturating perf counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        InstrReady,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        FetchErr,
  output logic [31:0] InstrCount,
  output logic [31:0] StallCount
);

  import fetch_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_fetch_err;
  logic [31:0]  w_next_pc;
  logic         w_misaligned;
  logic         w_accept;

  assign w_accept = (r_state == HOLD) && InstrReady;

  next_pc_sel u_next_pc_sel (
    .i_pc         (r_pc),
    .i_pc_src     (PCSrc),
    .i_imm_ext    (ImmExt),
    .i_alu_result (ALUResult),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates, so every flop samples pre-edge values regardless of block order.
    if (rst) r_state <= REQ;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      REQ:     w_next_state = WAIT;
      WAIT:    if (IMemRValid) w_next_state = HOLD;
      HOLD:    if (InstrReady) w_next_state = w_misaligned ? HALT : REQ;
      HALT:    w_next_state = HALT;
      default: w_next_state = REQ;
    endcase
  end

  // Handshake outputs are suppressed while reset is held, even before the first reset edge.
  always_comb begin
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    if (!rst) begin
      IMemReq    = (r_state == REQ);
      InstrValid = (r_state == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_fetch_err <= 1'b0;
    end else begin
      if ((r_state == WAIT) && IMemRValid) r_instr <= IMemRData;
      if (w_accept) begin
        if (w_misaligned) begin
          r_fetch_err <= 1'b1;
          r_instr     <= NOP_INSTR;
        end else begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  assign Instr    = r_instr;
  assign PC       = r_pc;
  assign PCPlus4  = r_pc + PC_INCR;
  assign IMemAddr = r_pc;
  assign FetchErr = r_fetch_err;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_instr_count;
  logic [31:0] r_stall_count;
  logic        w_stall;

  assign w_stall = (r_state == WAIT) || ((r_state == HOLD) && !InstrReady);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_accept && (r_instr_count != '1)) r_instr_count <= r_instr_count + 32'd1;
      if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign InstrCount = r_instr_count;
  assign StallCount = r_stall_count;
`else
  assign InstrCount = '0;
  assign StallCount = '0;
`endif

endmodule
